alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined successor to the team's 4-bit combinational ALU.
- Accepts operand pairs and an opcode through a valid/ready handshake and computes a WIDTH-bit result with status flags.
- Returns the result two cycles later through a back-pressurable output port.
- Holds an internal accumulator, so chained operations can take the previous result as operand A.
- Sits between an operand-issuing controller and a result consumer in the datapath.

## Interface
- WIDTH, 4: operand/result width; power of two, ≥ 4.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).

- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can take an operand beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- opcode  input  3  operation select.
- use_acc  input  1  replace A with the accumulator value.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- x  output  WIDTH  result.
- flags  output  4  {v, c, n, z}.
- acc  output  WIDTH  current accumulator value.

## Operation
Opcodes:
- 000 ADD: x = A+B mod 2^WIDTH; c = carry out; v = signed overflow.
- 001 SUB: x = A−B mod 2^WIDTH; c = borrow (A<B unsigned); v = signed overflow.
- 010 AND, 011 OR, 100 XOR: bitwise.
- 101 NOT: x = ~A; B ignored.
- 110 SHL: x = A << B[SHW-1:0], zero fill.
- 111 SHR: x = A >> B[SHW-1:0], logical, zero fill.
- c = v = 0 for opcodes 010–111.
- Shift amount 0 passes A through unchanged.

Flags, all opcodes:
- z = (x == 0).
- n = x[WIDTH-1].

Pipeline:
- Stage 1 (S1) registers a, b, opcode, use_acc on an input handshake (in_valid && in_ready).
- Stage 2 (S2) registers x and flags.
- Computation is combinational from S1 contents, performed on the S1→S2 transfer.
- Effective A = use_acc ? acc : S1.a, with acc sampled at the transfer.
- acc is loaded with the computed x on every S1→S2 transfer, for every opcode.
- acc therefore always holds the most recent computed result in issue order.
- Back-to-back use_acc beats chain correctly with no bubbles; no hazard logic is needed.

Advance rules:
- s2_adv = !out_valid || out_ready.
- s1_adv = s1_valid && s2_adv.
- in_ready = !s1_valid || s2_adv; combinational from out_ready.
- S2 capture: on s2_adv, out_valid ← s1_valid, and x/flags load if s1_valid.
- S1 capture: S1 loads when in_valid && in_ready; otherwise s1_valid clears on s1_adv.

Stall: while out_ready is low with out_valid high, x, flags, out_valid, S1 and acc all hold.

Reset:
- out_valid = 0, x = 0, flags = 0000, acc = 0, S1 contents and s1_valid = 0.
- in_ready reads 1 while rst is asserted and on the first cycle after.
- Assertion mid-operation discards all in-flight beats immediately; no partial result emerges.

## Timing
- Latency: input handshake at edge N → out_valid high after edge N+1 when unstalled.
- Throughput: one beat per cycle with out_ready held high.
- Full condition: S1 and S2 both occupied with out_ready low → in_ready = 0.
- Simultaneous output and input handshakes in one cycle: S2 takes S1's beat, S1 takes the new beat, and throughput is preserved.
- x/flags are stable whenever out_valid = 1 and out_ready = 0.
- No combinational path from a, b or opcode to any output; only out_ready → in_ready is combinational.

## Test plan
All scenarios use WIDTH = 4.

- ADD: a=0101, b=0011, op=000 → two cycles later x=1000, flags v=1 c=0 n=1 z=0; acc=1000.
- SUB wrap: a=0010, b=0011, op=001 → x=1111, c=1, n=1, v=0; then a=0011, b=0011 → x=0000, z=1, c=0.
- Logic and shift, streamed back-to-back with out_ready=1:
  - XOR 1010^0110 → 1100.
  - NOT 0011 → 1100.
  - SHL 0011 by 01 → 0110.
  - SHR 1110 by 11 → 0001.
  - Check: one result per cycle, in order, c=v=0.
- Accumulator chain: ADD a=0001, b=0001, then three beats of ADD use_acc=1, b=0101 issued consecutively → x = 0010, 0111, 1100, 0001 (last has c=1); acc ends at 0001.
- Back-pressure: issue 4 beats while out_ready=0 → exactly two accepted, in_ready=0 after that; x/flags stable; release out_ready → remaining beats flow, none lost or duplicated.
- Reset mid-stream: assert rst with S1 and S2 full → out_valid, x, flags and acc go 0 immediately; after release, the first new beat returns its correct result two cycles after acceptance.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The controller drives the master side; alu_pipe uses the slave side.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic             use_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic [3:0]       flags;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, a, b, opcode, use_acc, out_ready,
    input  in_ready, out_valid, x, flags, acc
  );

  modport slave (
    input  in_valid, a, b, opcode, use_acc, out_ready,
    output in_ready, out_valid, x, flags, acc
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with a result accumulator and valid/ready on both sides.
// S1 holds operands; the result is computed on the S1->S2 transfer and registered in S2.
module alu_pipe #(
  parameter int unsigned WIDTH = 4
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s1_use_acc;

  logic             out_valid_q;
  logic [WIDTH-1:0] x_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] acc_q;

  logic             s2_adv;
  logic             s1_adv;
  logic             in_fire;

  logic [WIDTH-1:0] eff_a;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic [3:0]       res_flags;

  // Only out_ready reaches in_ready combinationally.
  assign s2_adv  = !out_valid_q || bus.out_ready;
  assign s1_adv  = s1_valid && s2_adv;
  assign in_fire = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !s1_valid || s2_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.flags     = flags_q;
  assign bus.acc       = acc_q;

  // Result datapath from S1 contents; acc sampled at the transfer gives chaining for free.
  always_comb begin
    eff_a   = s1_use_acc ? acc_q : s1_a;
    add_ext = {1'b0, eff_a} + {1'b0, s1_b};
    sub_ext = {1'b0, eff_a} - {1'b0, s1_b};
    shamt   = s1_b[SHW-1:0];
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res   = add_ext[WIDTH-1:0];
        res_c = add_ext[WIDTH];
        res_v = (eff_a[WIDTH-1] == s1_b[WIDTH-1]) && (add_ext[WIDTH-1] != eff_a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = sub_ext[WIDTH-1:0];
        res_c = sub_ext[WIDTH];
        res_v = (eff_a[WIDTH-1] != s1_b[WIDTH-1]) && (sub_ext[WIDTH-1] != eff_a[WIDTH-1]);
      end
      OP_AND:  res = eff_a & s1_b;
      OP_OR:   res = eff_a | s1_b;
      OP_XOR:  res = eff_a ^ s1_b;
      OP_NOT:  res = ~eff_a;
      OP_SHL:  res = eff_a << shamt;
      OP_SHR:  res = eff_a >> shamt;
      default: res = '0;
    endcase
    res_flags = {res_v, res_c, res[WIDTH-1], (res == '0)};
  end

  // S1 operand stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= OP_ADD;
      s1_use_acc <= 1'b0;
    end else if (in_fire) begin
      s1_valid   <= 1'b1;
      s1_a       <= bus.a;
      s1_b       <= bus.b;
      s1_op      <= op_e'(bus.opcode);
      s1_use_acc <= bus.use_acc;
    end else if (s1_adv) begin
      s1_valid   <= 1'b0;
    end
  end

  // S2 result stage and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        x_q     <= res;
        flags_q <= res_flags;
        acc_q   <= res;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=4.
// Results are collected by a negedge monitor and compared against hand-computed values.
module tb_alu_pipe;
  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   accept_cyc;

  logic [7:0] res_q[$];
  int         cyc_q[$];

  alu_pipe_if #(.WIDTH(WIDTH)) bus ();

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output handshakes as {x, flags}, with the cycle they were presented.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      res_q.push_back({bus.x, bus.flags});
      cyc_q.push_back(cyc);
    end
  end

  task automatic align;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.opcode   = '0;
    bus.use_acc  = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) align();
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic drive_beat(input logic [3:0] va, input logic [3:0] vb,
                            input logic [2:0] op, input logic ua);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = va;
    bus.b        = vb;
    bus.opcode   = op;
    bus.use_acc  = ua;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: beat a=%b b=%b op=%b never accepted, required accept within 20 cycles", va, vb, op);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.x !== 4'b0000 || bus.flags !== 4'b0000 || bus.acc !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b x=%b flags=%b acc=%b, required 0 0000 0000 0000",
               bus.out_valid, bus.x, bus.flags, bus.acc);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    align();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready: got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_add;
    align();
    res_q.delete();
    cyc_q.delete();
    bus.out_ready = 1'b1;
    drive_beat(4'b0101, 4'b0011, 3'b000, 1'b0);
    idle();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_latency_early: out_valid=%b one cycle after accept, required 0", bus.out_valid);
    end
    align();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.x !== 4'b1000 || bus.flags !== 4'b1010) begin
      errors++;
      $display("FAIL add_result: out_valid=%b x=%b flags=%b, required 1 1000 1010",
               bus.out_valid, bus.x, bus.flags);
    end
    checks++;
    if (bus.acc !== 4'b1000) begin
      errors++;
      $display("FAIL add_acc: got %b, required 1000", bus.acc);
    end
    wait_cycles(2);
  endtask

  task automatic test_sub;
    align();
    res_q.delete();
    cyc_q.delete();
    bus.out_ready = 1'b1;
    drive_beat(4'b0010, 4'b0011, 3'b001, 1'b0);
    drive_beat(4'b0011, 4'b0011, 3'b001, 1'b0);
    idle();
    wait_cycles(4);
    checks++;
    if (res_q.size() != 2) begin
      errors++;
      $display("FAIL sub_count: got %0d results, required 2", res_q.size());
    end else begin
      checks++;
      if (res_q[0] !== 8'b1111_0110) begin
        errors++;
        $display("FAIL sub_wrap: {x,flags}=%b, required 11110110", res_q[0]);
      end
      checks++;
      if (res_q[1] !== 8'b0000_0001) begin
        errors++;
        $display("FAIL sub_zero: {x,flags}=%b, required 00000001", res_q[1]);
      end
    end
  endtask

  task automatic test_logic_shift;
    logic [7:0] exp_r [4];
    exp_r[0] = 8'b1100_0010;
    exp_r[1] = 8'b1100_0010;
    exp_r[2] = 8'b0110_0000;
    exp_r[3] = 8'b0001_0000;
    align();
    res_q.delete();
    cyc_q.delete();
    bus.out_ready = 1'b1;
    drive_beat(4'b1010, 4'b0110, 3'b100, 1'b0);
    drive_beat(4'b0011, 4'b1111, 3'b101, 1'b0);
    drive_beat(4'b0011, 4'b0001, 3'b110, 1'b0);
    drive_beat(4'b1110, 4'b0011, 3'b111, 1'b0);
    idle();
    wait_cycles(4);
    checks++;
    if (res_q.size() != 4) begin
      errors++;
      $display("FAIL logic_count: got %0d results, required 4", res_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (res_q[i] !== exp_r[i]) begin
          errors++;
          $display("FAIL logic_result[%0d]: {x,flags}=%b, required %b", i, res_q[i], exp_r[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cyc_q[i+1] - cyc_q[i] != 1) begin
          errors++;
          $display("FAIL logic_throughput[%0d]: gap %0d cycles, required 1", i, cyc_q[i+1] - cyc_q[i]);
        end
      end
    end
  endtask

  task automatic test_acc_chain;
    logic [7:0] exp_r [4];
    exp_r[0] = 8'b0010_0000;
    exp_r[1] = 8'b0111_0000;
    exp_r[2] = 8'b1100_1010;
    exp_r[3] = 8'b0001_0100;
    align();
    res_q.delete();
    cyc_q.delete();
    bus.out_ready = 1'b1;
    drive_beat(4'b0001, 4'b0001, 3'b000, 1'b0);
    drive_beat(4'b1111, 4'b0101, 3'b000, 1'b1);
    drive_beat(4'b1111, 4'b0101, 3'b000, 1'b1);
    drive_beat(4'b1111, 4'b0101, 3'b000, 1'b1);
    idle();
    wait_cycles(4);
    checks++;
    if (res_q.size() != 4) begin
      errors++;
      $display("FAIL chain_count: got %0d results, required 4", res_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (res_q[i] !== exp_r[i]) begin
          errors++;
          $display("FAIL chain_result[%0d]: {x,flags}=%b, required %b", i, res_q[i], exp_r[i]);
        end
      end
    end
    checks++;
    if (bus.acc !== 4'b0001) begin
      errors++;
      $display("FAIL chain_acc: got %b, required 0001", bus.acc);
    end
  endtask

  task automatic test_back_pressure;
    logic [7:0] exp_r [4];
    exp_r[0] = 8'b0011_0000;
    exp_r[1] = 8'b1000_1010;
    exp_r[2] = 8'b1110_0010;
    exp_r[3] = 8'b0000_0001;
    align();
    res_q.delete();
    cyc_q.delete();
    bus.out_ready = 1'b0;
    drive_beat(4'b0001, 4'b0010, 3'b000, 1'b0);
    drive_beat(4'b0100, 4'b0100, 3'b000, 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 4'b1111;
    bus.b        = 4'b0001;
    bus.opcode   = 3'b100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready[%0d]: got %b, required 0", i, bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.x !== 4'b0011 || bus.flags !== 4'b0000 || bus.acc !== 4'b0011) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b x=%b flags=%b acc=%b, required 1 0011 0000 0011",
                 i, bus.out_valid, bus.x, bus.flags, bus.acc);
      end
      align();
    end
    bus.out_ready = 1'b1;
    drive_beat(4'b1111, 4'b0001, 3'b100, 1'b0);
    drive_beat(4'b0000, 4'b0000, 3'b011, 1'b0);
    idle();
    wait_cycles(5);
    checks++;
    if (res_q.size() != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d results, required 4", res_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (res_q[i] !== exp_r[i]) begin
          errors++;
          $display("FAIL bp_result[%0d]: {x,flags}=%b, required %b", i, res_q[i], exp_r[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stream;
    align();
    bus.out_ready = 1'b0;
    drive_beat(4'b0111, 4'b0001, 3'b000, 1'b0);
    drive_beat(4'b0110, 4'b0011, 3'b010, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.x !== 4'b0000 || bus.flags !== 4'b0000 || bus.acc !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_clear: out_valid=%b x=%b flags=%b acc=%b, required 0 0000 0000 0000",
               bus.out_valid, bus.x, bus.flags, bus.acc);
    end
    align();
    rst = 1'b0;
    res_q.delete();
    cyc_q.delete();
    bus.out_ready = 1'b1;
    drive_beat(4'b0101, 4'b0001, 3'b001, 1'b0);
    idle();
    wait_cycles(4);
    checks++;
    if (res_q.size() != 1) begin
      errors++;
      $display("FAIL midreset_count: got %0d results, required 1", res_q.size());
    end else begin
      checks++;
      if (res_q[0] !== 8'b0100_0000) begin
        errors++;
        $display("FAIL midreset_result: {x,flags}=%b, required 01000000", res_q[0]);
      end
      checks++;
      if (cyc_q[0] - accept_cyc != 1) begin
        errors++;
        $display("FAIL midreset_latency: out_valid %0d cycles after accept edge, required 1", cyc_q[0] - accept_cyc);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    accept_cyc = 0;
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_acc_chain();
    test_back_pressure();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
